// File: rtl/uart_pkg.sv
// Shared constants for the UART TX arbiter: byte/grant widths and FSM state encodings.
package uart_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned GRANT_W = 3;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_HOLD      = 2'd3;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
module uart_rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (cand >= (PTR_W + 1)'(N_REQ)) begin
        cand = cand - (PTR_W + 1)'(N_REQ);
      end
      if (!any && req[cand[PTR_W-1:0]]) begin
        any = 1'b1;
        idx = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte sources, with optional
// packet lock and a start-without-busy timeout that drops the stuck byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter bit          LOCK_EN      = 1'b1,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*BYTE_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    grant_valid,
  output logic [GRANT_W-1:0]      grant_id,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic                    timeout_err
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic              lock_q, lock_d;
  logic              grant_valid_q, grant_valid_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic [BYTE_W-1:0] req_bytes [N_REQ];
  logic              pick_any;
  logic [PTR_W-1:0]  pick_idx;
  logic [PTR_W-1:0]  owner_next;
  logic [PTR_W-1:0]  sel;
  logic              take;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    owner_next = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    lock_d        = lock_q;
    grant_valid_d = grant_valid_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
    req_ready     = '0;
    sel           = (state_q == ST_HOLD) ? owner_q : pick_idx;
    take          = 1'b0;

    unique case (state_q)
      ST_IDLE: take = pick_any;
      ST_HOLD: take = req_valid[owner_q];
      ST_START: begin
        // tx_busy takes priority over an expiring timeout in the same cycle
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_d     = 1'b1;
          lock_d        = 1'b0;
          grant_valid_d = 1'b0;
          rr_ptr_d      = owner_next;
          state_d       = ST_IDLE;
        end else if (cnt_q < CNT_W'(BUSY_TIMEOUT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (lock_q) begin
            state_d = ST_HOLD;
          end else begin
            grant_valid_d = 1'b0;
            rr_ptr_d      = owner_next;
            state_d       = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      req_ready[sel] = 1'b1;
      data_d         = req_bytes[sel];
      owner_d        = sel;
      lock_d         = LOCK_EN && !req_last[sel];
      grant_valid_d  = 1'b1;
      cnt_d          = '0;
      state_d        = ST_START;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      lock_q        <= 1'b0;
      grant_valid_q <= 1'b0;
      data_q        <= '0;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      lock_q        <= lock_d;
      grant_valid_q <= grant_valid_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = GRANT_W'(owner_q);
  assign tx_start    = (state_q == ST_START);
  assign tx_data     = data_q;
  assign timeout_err = timeout_q;

endmodule
